fp_minmax_reduce: RTL
=====================

# fp_minmax_reduce

Streaming IEEE-754 min/max reduction unit for the floating-point ALU. It accepts a vector of `len` operands over a valid/ready input stream and selects the running maximum or minimum under IEEE-754 ordering. Ordering is sign-aware, ±0-aware and NaN-aware. It returns the winning value and its element index over a valid/ready output. It generalises the ALU's single-pair 32-bit comparator to a parametrised format, selectable mode and multi-element sequential operation.

## Interface

Parameters:
- `EXP_W`, 8, exponent width.
- `MAN_W`, 23, mantissa width; data width `W = 1+EXP_W+MAN_W`.
- `CNT_W`, 8, width of `len` and `out_index`.

Ports:
- `clk`  input  1  sole clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begins a reduction; sampled only in IDLE.
- `mode`  input  1  0 = max, 1 = min; latched on accepted `start`.
- `len`  input  CNT_W  element count; latched on accepted `start`.
- `in_valid`  input  1  `in_data` valid.
- `in_ready`  output  1  unit can accept an element.
- `in_data`  input  W  operand (sign, exponent, mantissa).
- `out_valid`  output  1  result available.
- `out_ready`  input  1  consumer accepts result.
- `out_data`  output  W  selected value.
- `out_index`  output  CNT_W  zero-based index of selected element.
- `nan_seen`  output  1  at least one NaN operand was in the vector.
- `busy`  output  1  high in ACCUM or DONE.

## Operation

- FSM states: IDLE, ACCUM, DONE.
- IDLE to ACCUM when `start=1` and `len!=0`.
  - On this transition, latch `mode` and `len`, clear the element counter, clear `nan_seen`, and mark best-register empty.
- IDLE to DONE when `start=1` and `len=0`.
  - Result is the canonical qNaN: sign 0, exponent all ones, mantissa MSB 1, rest 0.
  - `out_index=0`, `nan_seen=0`.
- ACCUM:
  - An element is accepted on each cycle with `in_valid & in_ready`.
  - The counter increments per acceptance.
  - After the `len`-th acceptance, go to DONE.
- DONE to IDLE on `out_valid & out_ready`.
- `start` outside IDLE is ignored; it is not queued.
- NaN detection: exponent all ones and mantissa non-zero.
- Comparison of candidate `c` against best `b`, with NaNs excluded:
  - Magnitude field `{exp,man}` is compared unsigned.
  - If the signs differ, the positive value is larger.
  - If both are positive, the larger magnitude is larger.
  - If both are negative, the smaller magnitude is larger.
  - +0 is greater than −0.
  - ±Inf are ordered normally.
- Update rules:
  - If best is empty and `c` is non-NaN, load `c` and its index.
  - If `c` is NaN, set `nan_seen` and leave best unchanged.
  - If `c` is strictly greater (max mode) or strictly smaller (min mode), replace best.
  - Ties keep the earlier index.
- If all elements are NaN, the result is the canonical qNaN, `out_index=0`, `nan_seen=1`.
- Result is the pass-through bit pattern of the winning operand; no normalisation and no NaN quieting of non-NaN values.

## Timing

- Reset values:
  - State IDLE.
  - `in_ready=0`, `out_valid=0`, `out_data=0`, `out_index=0`, `nan_seen=0`, `busy=0`.
  - Counter and best-register cleared.
- `in_ready=1` exactly while in ACCUM; it is a registered state decode and does not depend on `in_valid`.
- Throughput: one element per cycle, with no bubbles while `in_valid` is held high.
- Latency: `out_valid` rises the cycle after the last element is accepted (1 cycle). For `len=0` it rises the cycle after `start`.
- `out_valid`, `out_data`, `out_index` and `nan_seen` hold stable in DONE until the handshake completes. `out_valid` falls the cycle after `out_ready`.
- `busy` goes low the cycle after the output handshake. A new `start` is accepted from that cycle onward.
- `rst` asserted in any state, including mid-vector with partial results, returns to IDLE on the next edge and discards all state. No output is produced for the aborted vector.
- `len` is maximal at 2^CNT_W−1; the counter never wraps within a vector.

## Test plan

- Max, `len=3`, input {0x3F800000, 0xC0000000, 0x40600000} → `out_data=0x40600000`, `out_index=2`, `nan_seen=0`, `out_valid` one cycle after third accept.
- Min, same vector → `0xC0000000`, `out_index=1`. Tie check: max of {0x40000000, 0x40000000} → `out_index=0`.
- NaN handling: max of {0x7FC00000, 0xBF800000, 0x7F800001} → `0xBF800000`, index 1, `nan_seen=1`. All-NaN {0xFFC00000} → `0x7FC00000`, index 0, `nan_seen=1`.
- Signed zero and infinity:
  - Max of {0x80000000, 0x00000000} → `0x00000000`, index 1.
  - Min of the same → `0x80000000`, index 0.
  - Max of {0xFF800000, 0x7F800000} → `0x7F800000`, index 1.
- Handshake stress:
  - `in_valid` gapped (1,0,0,1,1) with `len=3`: result correct.
  - `out_ready` held low 4 cycles: outputs stable, `start` pulses ignored.
  - `len=0`: qNaN on the cycle after `start`.
- Reset mid-op: assert `rst` after 2 of 5 elements → next cycle IDLE, all outputs at reset values. A fresh `len=1` vector {0x41200000} then returns 0x41200000, index 0.

Source files
------------

// File: rtl/fp_minmax_reduce_if.sv
// Stream bundle for fp_minmax_reduce: command (start/mode/len), operand
// stream (in_valid/in_ready/in_data), result stream (out_valid/out_ready/
// out_data/out_index/nan_seen) and busy status.
// master = producer/consumer side (bench or ALU sequencer), slave = reduction unit.
interface fp_minmax_reduce_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 8
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             start;
    logic             mode;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] out_index;
    logic             nan_seen;
    logic             busy;

    modport master (
        output start, mode, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, nan_seen, busy
    );

    modport slave (
        input  start, mode, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, nan_seen, busy
    );
endinterface

// File: rtl/fp_minmax_reduce.sv
// Streaming IEEE-754 max/min reduction over len operands, returning winner value + index.
// Latency: result valid 1 cycle after the last accepted element (1 cycle after start for len=0).
// Backpressure: in_ready is a registered ACCUM decode; result held in DONE until out_ready.
// Ports: clk, rst (sync active-high), bus (slave modport of fp_minmax_reduce_if).
module fp_minmax_reduce #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_minmax_reduce_if.slave     bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_nxt;
    logic             mode_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] idx_q;
    logic [W-1:0]     best_q;
    logic             best_vld_q;
    logic             nan_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // Candidate decode and IEEE ordering against the current best.
    logic             accept;
    logic             last;
    logic             c_sign, b_sign;
    logic [W-2:0]     c_mag, b_mag;
    logic             c_nan;
    logic             c_gt_b, c_lt_b;
    logic             take;

    assign accept = bus.in_valid & in_ready_q;
    // len_q >= 1 in ACCUM, so len_q-1 never underflows while this matters.
    assign last   = accept && (cnt_q == len_q - CNT_ONE);

    assign c_sign = bus.in_data[W-1];
    assign c_mag  = bus.in_data[W-2:0];
    assign b_sign = best_q[W-1];
    assign b_mag  = best_q[W-2:0];
    assign c_nan  = (&bus.in_data[W-2:MAN_W]) && (|bus.in_data[MAN_W-1:0]);

    // Differing signs: the positive one is larger, which also orders +0 above -0.
    // Same sign: magnitude order, inverted for negatives.
    assign c_gt_b = (c_sign != b_sign) ? !c_sign : (c_sign ? (c_mag < b_mag) : (c_mag > b_mag));
    assign c_lt_b = (c_sign != b_sign) ?  c_sign : (c_sign ? (c_mag > b_mag) : (c_mag < b_mag));

    // Strict comparison so ties keep the earlier index; NaNs never win.
    assign take = !c_nan && (!best_vld_q || (mode_q ? c_lt_b : c_gt_b));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.len == '0) ? DONE : ACCUM;
            ACCUM:   if (last) state_nxt = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt == ACCUM);
            out_valid_q <= (state_nxt == DONE);
            busy_q      <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_vld_q <= 1'b0;
            nan_q      <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            mode_q     <= bus.mode;
            len_q      <= bus.len;
            cnt_q      <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_vld_q <= 1'b0;
            nan_q      <= 1'b0;
        end else if (accept) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (c_nan) nan_q <= 1'b1;
            if (take) begin
                best_q     <= bus.in_data;
                idx_q      <= cnt_q;
                best_vld_q <= 1'b1;
            end
        end
    end

    // An empty best register at DONE means no non-NaN operand: report canonical qNaN.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.nan_seen  = nan_q;
    assign bus.out_data  = out_valid_q ? (best_vld_q ? best_q : QNAN) : '0;
    assign bus.out_index = (out_valid_q && best_vld_q) ? idx_q : '0;
endmodule
